tt_input_conditioner: RTL and testbench

//  Conditions the 8 raw dedicated input pins before they reach the art-tile core logic.
//  Per bit, it provides:
//   - a multi-flop synchroniser;
//   - a counter-based debouncer;
//   - rise and fall edge detection.

---
 rtl/tt_input_conditioner_pkg.sv | 14 +
 rtl/tt_input_conditioner_if.sv | 26 ++
 rtl/tt_input_conditioner_debounce.sv | 78 +++++++
 rtl/tt_input_conditioner.sv | 56 +++++
 tb/tb_tt_input_conditioner.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/tt_input_conditioner_pkg.sv
// Shared constants for the art-tile input conditioner: default geometry and
// the debounce counter width derivation used by the top and the per-bit slice.
package tt_input_conditioner_pkg;

  localparam int unsigned TT_WIDTH           = 8;
  localparam int unsigned TT_SYNC_STAGES     = 2;
  localparam int unsigned TT_DEBOUNCE_CYCLES = 16;

  // Counter only has to reach DEBOUNCE_CYCLES-1, so clog2 of the cycle count suffices.
  function automatic int unsigned tt_cnt_w(input int unsigned cycles);
    return (cycles <= 32'd2) ? 32'd1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/tt_input_conditioner_if.sv
// Pin-side bundle of the input conditioner: raw pins and enable in,
// clean level, edge strobes and the aligned change flag out.
interface tt_input_conditioner_if
  import tt_input_conditioner_pkg::*;
#(
  parameter int unsigned WIDTH = TT_WIDTH
);

  logic             ena;
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] clean_out;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;
  logic             change_valid;

  modport master (
    output ena, raw_in,
    input  clean_out, rise_pulse, fall_pulse, change_valid
  );

  modport slave (
    input  ena, raw_in,
    output clean_out, rise_pulse, fall_pulse, change_valid
  );

endinterface

// File: rtl/tt_input_conditioner_debounce.sv
// One conditioned bit: synchroniser chain, debounce counter, clean level flop
// and registered rise/fall strobes.
module tt_debounce_bit
  import tt_input_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = TT_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = TT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic raw_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o,
  output logic accept_o
);

  localparam int unsigned CNT_W = tt_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  (* async_reg = "true" *) logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync_s;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Next-state: sync keeps shifting regardless of ena; debounce state only moves when enabled.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], raw_i};
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (ena) begin
      if (sync_s == clean_q) begin
        cnt_d = {CNT_W{1'b0}};
      end else if (cnt_q == CNT_MAX) begin
        clean_d = sync_s;
        cnt_d   = {CNT_W{1'b0}};
        rise_d  = sync_s;
        fall_d  = ~sync_s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {SYNC_STAGES{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean_o  = clean_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  // Pre-register acceptance lets the top register change_valid in step with the strobes.
  assign accept_o = rise_d | fall_d;

endmodule

// File: rtl/tt_input_conditioner.sv
// Conditions the tile's dedicated input pins: WIDTH independent debounce slices
// plus a single registered change flag aligned with their edge strobes.
module tt_input_conditioner
  import tt_input_conditioner_pkg::*;
#(
  parameter int unsigned WIDTH           = TT_WIDTH,
  parameter int unsigned SYNC_STAGES     = TT_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = TT_DEBOUNCE_CYCLES
) (
  input logic                    clk,
  input logic                    rst_n,
  tt_input_conditioner_if.slave  bus
);

  logic [WIDTH-1:0] clean_s;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] accept_s;
  logic             change_valid_q, change_valid_d;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    tt_debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (bus.ena),
      .raw_i    (bus.raw_in[g]),
      .clean_o  (clean_s[g]),
      .rise_o   (rise_s[g]),
      .fall_o   (fall_s[g]),
      .accept_o (accept_s[g])
    );
  end

  // Any bit accepting this edge raises one shared strobe.
  always_comb begin
    change_valid_d = |accept_s;
  end

  // Change flag register, cleared with the rest of the conditioner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      change_valid_q <= 1'b0;
    end else begin
      change_valid_q <= change_valid_d;
    end
  end

  assign bus.clean_out    = clean_s;
  assign bus.rise_pulse   = rise_s;
  assign bus.fall_pulse   = fall_s;
  assign bus.change_valid = change_valid_q;

endmodule

// File: tb/tb_tt_input_conditioner.sv
// Bench for tt_input_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4:
// directed scenarios with literal expectations plus randomized pins against a vector model.
module tb_tt_input_conditioner;

  localparam int W    = 8;
  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  tt_input_conditioner_if #(.WIDTH(W)) bus ();

  tt_input_conditioner #(
    .WIDTH           (W),
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  bit live  = 1'b0;

  // Reference model: raw delayed SYNC edges, per-bit run length of differing enabled samples.
  logic [W-1:0] dly [SYNC];
  int           run [W];
  logic [W-1:0] m_clean, m_rise, m_fall;
  logic         m_cv;
  logic [W-1:0] s_m, rdy, acc;

  always_comb begin
    s_m = dly[SYNC-1];
    rdy = '0;
    for (int i = 0; i < W; i++) rdy[i] = (run[i] == DEB - 1);
    acc = bus.ena ? ((s_m ^ m_clean) & rdy) : '0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC; k++) dly[k] <= '0;
      for (int i = 0; i < W; i++) run[i] <= 0;
      m_clean <= '0;
      m_rise  <= '0;
      m_fall  <= '0;
      m_cv    <= 1'b0;
    end else begin
      dly[0] <= bus.raw_in;
      for (int k = 1; k < SYNC; k++) dly[k] <= dly[k-1];
      m_clean <= m_clean ^ acc;
      m_rise  <= acc & s_m;
      m_fall  <= acc & ~s_m;
      m_cv    <= |acc;
      if (bus.ena) begin
        for (int i = 0; i < W; i++) begin
          if (s_m[i] != m_clean[i]) run[i] <= rdy[i] ? 0 : run[i] + 1;
          else                      run[i] <= 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock and compare every output to the model away from the edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (live && rst_n) begin
      chk("model_clean", bus.clean_out, m_clean);
      chk("model_rise",  bus.rise_pulse, m_rise);
      chk("model_fall",  bus.fall_pulse, m_fall);
      chk("model_cv",    {7'd0, bus.change_valid}, {7'd0, m_cv});
    end
  endtask

  task automatic chk_all(input string name, input logic [W-1:0] c, input logic [W-1:0] r,
                         input logic [W-1:0] f, input logic cv);
    chk({name, "_clean"}, bus.clean_out, c);
    chk({name, "_rise"},  bus.rise_pulse, r);
    chk({name, "_fall"},  bus.fall_pulse, f);
    chk({name, "_cv"},    {7'd0, bus.change_valid}, {7'd0, cv});
  endtask

  initial begin
    bus.ena    = 1'b1;
    bus.raw_in = 8'h00;
    #1 rst_n = 1'b0;
    bus.raw_in = 8'hFF;
    #1;
    chk_all("t1_reset", 8'h00, 8'h00, 8'h00, 1'b0);
    live = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k < 6)       chk_all("t1_wait", 8'h00, 8'h00, 8'h00, 1'b0);
      else if (k == 6) begin
        chk_all("t1_edge6", 8'hFF, 8'hFF, 8'h00, 1'b1);
        chk("t1_model", m_clean, 8'hFF);
      end else         chk_all("t1_after", 8'hFF, 8'h00, 8'h00, 1'b0);
    end

    // Bounce on bit 0
    bus.raw_in = 8'h00;
    repeat (10) step();
    chk("t2_low", bus.clean_out, 8'h00);
    bus.raw_in = 8'h01; step();
    bus.raw_in = 8'h00; step();
    bus.raw_in = 8'h01;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k < 6)       chk_all("t2_wait", 8'h00, 8'h00, 8'h00, 1'b0);
      else if (k == 6) chk_all("t2_edge6", 8'h01, 8'h01, 8'h00, 1'b1);
      else             chk_all("t2_after", 8'h01, 8'h00, 8'h00, 1'b0);
    end

    // Glitch on bit 3 shorter than the debounce window
    bus.raw_in = 8'h09;
    repeat (3) step();
    bus.raw_in = 8'h01;
    repeat (10) begin
      step();
      chk_all("t3_glitch", 8'h01, 8'h00, 8'h00, 1'b0);
    end

    // Freeze mid-count on bit 5
    bus.raw_in = 8'h21;
    repeat (4) step();
    bus.ena = 1'b0;
    repeat (10) begin
      step();
      chk_all("t4_frozen", 8'h01, 8'h00, 8'h00, 1'b0);
    end
    bus.ena = 1'b1;
    step();
    chk_all("t4_resume1", 8'h01, 8'h00, 8'h00, 1'b0);
    step();
    chk_all("t4_resume2", 8'h21, 8'h20, 8'h00, 1'b1);
    chk("t4_model", m_rise, 8'h20);

    // Simultaneous accept on all bits
    bus.raw_in = 8'h0F;
    repeat (8) step();
    chk("t5_pre", bus.clean_out, 8'h0F);
    bus.raw_in = 8'hF0;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k < 6)       chk_all("t5_wait", 8'h0F, 8'h00, 8'h00, 1'b0);
      else if (k == 6) chk_all("t5_edge6", 8'hF0, 8'hF0, 8'h0F, 1'b1);
      else             chk_all("t5_after", 8'hF0, 8'h00, 8'h00, 1'b0);
    end

    // Reset during count 2 loses all progress
    bus.raw_in = 8'hFF;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    chk_all("t6_async", 8'h00, 8'h00, 8'h00, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k < 6) chk_all("t6_wait", 8'h00, 8'h00, 8'h00, 1'b0);
      else       chk_all("t6_edge6", 8'hFF, 8'hFF, 8'h00, 1'b1);
    end

    // Randomized pins, enable and one mid-run reset
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 7) == 0)       bus.raw_in = 8'($urandom);
      else if ($urandom_range(0, 5) == 0)  bus.raw_in = bus.raw_in ^ (8'd1 << $urandom_range(0, 7));
      bus.ena = ($urandom_range(0, 9) != 0);
      if (n == 400) begin
        rst_n = 1'b0;
        #1;
        chk_all("rnd_reset", 8'h00, 8'h00, 8'h00, 1'b0);
      end
      if (n == 402) rst_n = 1'b1;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
